stream_parser: RTL and testbench
================================

STREAM_PARSER -- requirements
Module: stream_parser

Interface
REQ-001 SHALL have parameter NUM_STREAMS, default 32, number of tracked streams (power of 2, 2..256).
REQ-002 SHALL have parameter MAX_BYTES, default 37, maximum payload bytes per packet (4..256).
REQ-003 SHALL have parameter QDEPTH, default 2, output queue entries (1..4).
REQ-004 SHALL have ports:
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- dataIn  in  32  input word, big-endian byte lanes
- dataIn_val  in  1  input word valid
- dataIn_ready  out  1  input word accepted when val&ready
- dataIN_last  in  1  final word of packet
- dataOut  out  MAX_BYTES*8  payload, byte 0 in MSBs, unused bytes zero
- dataOut_bytes  out  9  valid payload byte count
- dataOut_stream  out  16  stream id from header
- dataOut_seq  out  32  sequence number from header
- dataOut_val  out  1  queue head valid
- dataOut_ready  in  1  consumer accepts head when val&ready
- packetLost  out  1  head packet's sequence was not previous+1
- lenError  out  1  one-cycle pulse: malformed packet dropped

Function
REQ-005 SHALL parse word 0 as length[31:16] (total bytes incl. 8-byte header) and stream id[15:0]; word 1 as sequence; words 2.. as payload.
REQ-006 SHALL index stream state by id[log2(NUM_STREAMS)-1:0].
REQ-007 SHALL use states IDLE, GET_SEQ, GET_DATA, DRAIN, COMMIT; transition only on accepted words, except COMMIT, which lasts exactly one cycle.
REQ-008 SHALL transition IDLE->GET_SEQ on accepted header. Go to DRAIN instead if length<9 or length-8>MAX_BYTES.
REQ-009 SHALL transition GET_SEQ->GET_DATA on accepted word; dataIN_last on this word SHALL pulse lenError and return to IDLE.
REQ-010 SHALL in GET_DATA store each word at payload offset 4*k; on the word where bytesLeft<=4, bytes beyond bytesLeft SHALL be zeroed.
REQ-011 SHALL go GET_DATA->COMMIT when last arrives with bytesLeft<=4. Last with bytesLeft>4 SHALL pulse lenError and go to IDLE. bytesLeft<=4 without last SHALL pulse lenError and go to DRAIN.
REQ-012 SHALL in DRAIN accept and discard words until dataIN_last, then go IDLE.
REQ-013 SHALL in COMMIT push {payload, bytes, stream, seq, lost} into queue, clear payload buffer, write seqs[stream]<=seq.
REQ-014 SHALL compute lost = (seq != seqs[stream]+1), modulo 2^32 (0xFFFFFFFF->0 is not lost); dropped packets SHALL NOT update seqs.
REQ-015 SHALL drive dataIn_ready = (state!=COMMIT) && (queue count<QDEPTH || state is IDLE/GET_SEQ/DRAIN).
REQ-016 SHALL assert dataOut_val the cycle after COMMIT when queue was empty (last word accepted cycle N -> val at N+2).
REQ-017 SHALL allow push and pop in the same cycle, count unchanged; head outputs stable while val&&!ready.
REQ-018 SHALL deliver queued packets in commit order.
REQ-019 SHALL restart at IDLE after a dropped packet with no residual payload or state.

Reset
REQ-020 SHALL on reset: state IDLE, queue empty, dataOut_val=0, packetLost=0, lenError=0, dataOut/bytes/stream/seq=0, all seqs=0, payload buffer zero.
REQ-021 SHALL on reset mid-packet discard the partial packet; the next accepted word is a header.

Configuration
REQ-022 SHALL, when STREAM_PARSER_GAP_COUNT_EN is defined, add output lostCount (32) per queue entry = seq-(seqs[stream]+1) mod 2^32 for lost packets, 0 otherwise.
REQ-023 SHALL, without STREAM_PARSER_GAP_COUNT_EN, omit lostCount port and its logic entirely.

Verification
REQ-024 Header 0x000D0003, seq 1, words 0xAABBCCDD, 0x11223344(last) -> dataOut bytes AABBCCDD11, bytes=5, stream=3, packetLost=0, val 2 cycles after last.
REQ-025 Stream 3 seq 1 then seq 4 -> second packetLost=1; with GAP_COUNT lostCount=2; stream 5 seq 1 not lost.
REQ-026 Length 0x0100 with MAX_BYTES=37 -> lenError pulse, words drained to last, no output, seqs unchanged.
REQ-027 dataOut_ready=0, three back-to-back packets, QDEPTH=2 -> dataIn_ready low at third packet's data; ready=1 -> three packets in order.
REQ-028 Reset asserted during GET_DATA -> val=0, next header parsed correctly, seq 1 not lost.
REQ-029 seqs[stream]=0xFFFFFFFF then seq 0 -> packetLost=0.

Source files
------------

// File: rtl/stream_parser.sv
// stream_parser: splits a 32-bit word stream into packets (length/stream
// header, sequence word, payload), tracks the last sequence number seen per
// stream to flag gaps, and hands complete packets out through a small queue.
// Optional feature: define STREAM_PARSER_GAP_COUNT_EN to add the lostCount
// output, which reports how many sequence numbers were skipped.
module stream_parser #(
  parameter int NUM_STREAMS = 32,
  parameter int MAX_BYTES   = 37,
  parameter int QDEPTH      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            dataIn,
  input  logic                   dataIn_val,
  output logic                   dataIn_ready,
  input  logic                   dataIN_last,
  output logic [MAX_BYTES*8-1:0] dataOut,
  output logic [8:0]             dataOut_bytes,
  output logic [15:0]            dataOut_stream,
  output logic [31:0]            dataOut_seq,
  output logic                   dataOut_val,
  input  logic                   dataOut_ready,
  output logic                   packetLost,
  output logic                   lenError
`ifdef STREAM_PARSER_GAP_COUNT_EN
  ,
  output logic [31:0]            lostCount
`endif
);

  localparam int IDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int PAY_W = MAX_BYTES * 8;
`ifdef STREAM_PARSER_GAP_COUNT_EN
  localparam int GAP_W = 32;
`else
  localparam int GAP_W = 0;
`endif
  // Queue entry layout, LSB first: [gap], lost, seq, stream, bytes, payload
  localparam int LOST_LSB   = GAP_W;
  localparam int SEQ_LSB    = GAP_W + 1;
  localparam int STREAM_LSB = GAP_W + 33;
  localparam int BYTES_LSB  = GAP_W + 49;
  localparam int PAY_LSB    = GAP_W + 58;
  localparam int ENTRY_W    = PAY_LSB + PAY_W;

  typedef enum logic [2:0] {IDLE, GET_SEQ, GET_DATA, DRAIN, COMMIT} stateType;

  stateType          stateReg, stateNext;
  logic [8:0]        bytesReg, bytesLeftReg, byteOffReg;
  logic [15:0]       streamReg;
  logic [31:0]       seqReg, prevSeqReg;
  logic [PAY_W-1:0]  payloadReg, payloadNext;
  logic [31:0]       seqs [NUM_STREAMS];
  logic              lenErrorReg, lenErrorNext;
  logic [ENTRY_W-1:0] queue [QDEPTH];
  logic [ENTRY_W-1:0] newEntry, head;
  logic [2:0]        countReg;

  logic              accept, push, pop;
  logic              loadHeader, loadSeq, storeWord, advance, clearPayload;
  logic [15:0]       headerLen;
  logic              badLen, finalWord;
  logic [31:0]       expectedSeq;
  logic              lostNow;
  logic [7:0]        inLane [4];
  logic [PAY_W-1:0]  laneData, laneMask;

  assign headerLen = dataIn[31:16];
  // Payload must be 1..MAX_BYTES bytes after the 8-byte header
  assign badLen    = (headerLen < 16'd9) || ((headerLen - 16'd8) > 16'(MAX_BYTES));
  assign finalWord = (bytesLeftReg <= 9'd4);

  // Only GET_DATA can lead to a push, so only it is held off by a full queue
  assign dataIn_ready = (stateReg != COMMIT) &&
                        ((countReg < 3'(QDEPTH)) || (stateReg == IDLE) ||
                         (stateReg == GET_SEQ) || (stateReg == DRAIN));
  assign accept = dataIn_val && dataIn_ready;
  assign push   = (stateReg == COMMIT);
  assign pop    = (countReg != 3'd0) && dataOut_ready;

  // Big-endian byte lanes of the input word
  for (genvar gi = 0; gi < 4; gi++) begin : gInLane
    assign inLane[gi] = dataIn[31-8*gi -: 8];
  end

  // Per payload byte: is it covered by the current word, and with which value
  for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : gByteLane
    logic [9:0] rel;
    logic       hit;
    assign rel = 10'(gi) - {1'b0, byteOffReg};
    assign hit = (rel < 10'd4);
    assign laneMask[(MAX_BYTES-1-gi)*8 +: 8] = {8{hit}};
    assign laneData[(MAX_BYTES-1-gi)*8 +: 8] =
      (hit && (rel < {1'b0, bytesLeftReg})) ? inLane[rel[1:0]] : 8'h00;
  end

  // Next-state and per-word control decisions
  always_comb begin
    stateNext    = stateReg;
    lenErrorNext = 1'b0;
    loadHeader   = 1'b0;
    loadSeq      = 1'b0;
    storeWord    = 1'b0;
    advance      = 1'b0;
    clearPayload = 1'b0;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          loadHeader   = 1'b1;
          clearPayload = 1'b1;
          if (dataIN_last) begin
            // Header-only packet: already ended, nothing left to drain
            lenErrorNext = 1'b1;
          end else if (badLen) begin
            lenErrorNext = 1'b1;
            stateNext    = DRAIN;
          end else begin
            stateNext = GET_SEQ;
          end
        end
      end
      GET_SEQ: begin
        if (accept) begin
          if (dataIN_last) begin
            lenErrorNext = 1'b1;
            stateNext    = IDLE;
          end else begin
            loadSeq   = 1'b1;
            stateNext = GET_DATA;
          end
        end
      end
      GET_DATA: begin
        if (accept) begin
          if (finalWord) begin
            if (dataIN_last) begin
              storeWord = 1'b1;
              stateNext = COMMIT;
            end else begin
              lenErrorNext = 1'b1;
              clearPayload = 1'b1;
              stateNext    = DRAIN;
            end
          end else if (dataIN_last) begin
            lenErrorNext = 1'b1;
            clearPayload = 1'b1;
            stateNext    = IDLE;
          end else begin
            storeWord = 1'b1;
            advance   = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && dataIN_last) stateNext = IDLE;
      end
      COMMIT: begin
        clearPayload = 1'b1;
        stateNext    = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Payload buffer merge: clear on new packet/drop/commit, else write word lanes
  always_comb begin
    payloadNext = payloadReg;
    if (clearPayload) begin
      payloadNext = '0;
    end else if (storeWord) begin
      payloadNext = (payloadReg & ~laneMask) | laneData;
    end
  end

  // Parser state, header fields and payload registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= IDLE;
      lenErrorReg  <= 1'b0;
      payloadReg   <= '0;
      bytesReg     <= '0;
      bytesLeftReg <= '0;
      byteOffReg   <= '0;
      streamReg    <= '0;
      seqReg       <= '0;
      prevSeqReg   <= '0;
    end else begin
      stateReg    <= stateNext;
      lenErrorReg <= lenErrorNext;
      payloadReg  <= payloadNext;
      if (loadHeader) begin
        bytesReg     <= 9'(headerLen - 16'd8);
        bytesLeftReg <= 9'(headerLen - 16'd8);
        byteOffReg   <= '0;
        streamReg    <= dataIn[15:0];
        // Safe to sample early: seqs only changes in COMMIT, when no header is taken
        prevSeqReg   <= seqs[dataIn[IDX_W-1:0]];
      end
      if (loadSeq) seqReg <= dataIn;
      if (advance) begin
        bytesLeftReg <= bytesLeftReg - 9'd4;
        byteOffReg   <= byteOffReg + 9'd4;
      end
    end
  end

  // Last committed sequence number per stream; dropped packets never touch it
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STREAMS; i++) seqs[i] <= '0;
    end else if (push) begin
      seqs[streamReg[IDX_W-1:0]] <= seqReg;
    end
  end

  assign expectedSeq = prevSeqReg + 32'd1;
  assign lostNow     = (seqReg != expectedSeq);

`ifdef STREAM_PARSER_GAP_COUNT_EN
  assign newEntry = {payloadReg, bytesReg, streamReg, seqReg, lostNow,
                     (lostNow ? (seqReg - expectedSeq) : 32'd0)};
`else
  assign newEntry = {payloadReg, bytesReg, streamReg, seqReg, lostNow};
`endif

  // Shift queue: entry 0 is the head; a pop shifts down, a push fills the tail
  always_ff @(posedge clk) begin
    if (reset) begin
      countReg <= '0;
      for (int i = 0; i < QDEPTH; i++) queue[i] <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (pop) begin
          if (push && (i == int'(countReg) - 1)) queue[i] <= newEntry;
          else queue[i] <= queue[(i < QDEPTH-1) ? i+1 : i];
        end else if (push && (i == int'(countReg))) begin
          queue[i] <= newEntry;
        end
      end
      if (push && !pop) countReg <= countReg + 3'd1;
      else if (pop && !push) countReg <= countReg - 3'd1;
    end
  end

  assign head           = queue[0];
  assign dataOut_val    = (countReg != 3'd0);
  assign dataOut        = dataOut_val ? head[PAY_LSB +: PAY_W] : '0;
  assign dataOut_bytes  = dataOut_val ? head[BYTES_LSB +: 9] : '0;
  assign dataOut_stream = dataOut_val ? head[STREAM_LSB +: 16] : '0;
  assign dataOut_seq    = dataOut_val ? head[SEQ_LSB +: 32] : '0;
  assign packetLost     = dataOut_val && head[LOST_LSB];
  assign lenError       = lenErrorReg;
`ifdef STREAM_PARSER_GAP_COUNT_EN
  assign lostCount      = dataOut_val ? head[31:0] : '0;
`endif

endmodule

// File: tb/tb_stream_parser.sv
// Directed self-checking bench for stream_parser (default parameters).
module tb_stream_parser;
  localparam int MB = 37;
  localparam int PW = MB * 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   dataIn;
  logic          dataIn_val;
  logic          dataIn_ready;
  logic          dataIN_last;
  logic [PW-1:0] dataOut;
  logic [8:0]    dataOut_bytes;
  logic [15:0]   dataOut_stream;
  logic [31:0]   dataOut_seq;
  logic          dataOut_val;
  logic          dataOut_ready;
  logic          packetLost;
  logic          lenError;
`ifdef STREAM_PARSER_GAP_COUNT_EN
  logic [31:0]   lostCount;
`endif

  always #5 clk = ~clk;

  stream_parser #(.NUM_STREAMS(32), .MAX_BYTES(MB), .QDEPTH(2)) dut (
    .clk(clk),
    .reset(reset),
    .dataIn(dataIn),
    .dataIn_val(dataIn_val),
    .dataIn_ready(dataIn_ready),
    .dataIN_last(dataIN_last),
    .dataOut(dataOut),
    .dataOut_bytes(dataOut_bytes),
    .dataOut_stream(dataOut_stream),
    .dataOut_seq(dataOut_seq),
    .dataOut_val(dataOut_val),
    .dataOut_ready(dataOut_ready),
    .packetLost(packetLost),
    .lenError(lenError)
`ifdef STREAM_PARSER_GAP_COUNT_EN
    ,
    .lostCount(lostCount)
`endif
  );

  int checkCount = 0;
  int passCount  = 0;
  logic [31:0] pl [10];

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected payload: first nb bytes of pl[], big-endian, rest zero
  function automatic logic [PW-1:0] expPay(input int nb);
    logic [PW-1:0] r;
    logic [31:0]   w;
    r = '0;
    for (int b = 0; b < nb; b++) begin
      w = pl[b/4];
      r[PW-1-8*b -: 8] = w[31-8*(b%4) -: 8];
    end
    return r;
  endfunction

  // Present one word from a negedge; returns at the negedge after acceptance
  task automatic sendWord(input logic [31:0] w, input logic l);
    int n;
    n = 0;
    dataIn = w; dataIN_last = l; dataIn_val = 1'b1;
    while (!dataIn_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("inReadyTimeout", PW'(n), PW'(0));
    @(negedge clk);
    dataIn_val = 1'b0; dataIN_last = 1'b0;
  endtask

  task automatic sendPkt(input logic [15:0] len, input logic [15:0] sid,
                         input logic [31:0] seq, input int nw);
    sendWord({len, sid}, 1'b0);
    sendWord(seq, 1'b0);
    for (int k = 0; k < nw; k++) sendWord(pl[k], k == nw - 1);
  endtask

  task automatic popPkt(input string tag, input logic [15:0] sid, input logic [31:0] seq,
                        input int nb, input logic lost, input logic [31:0] gap);
    int n;
    n = 0;
    while (!dataOut_val && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_val"}, PW'(dataOut_val), PW'(1));
    check({tag, "_pay"}, dataOut, expPay(nb));
    check({tag, "_bytes"}, PW'(dataOut_bytes), PW'(nb));
    check({tag, "_stream"}, PW'(dataOut_stream), PW'(sid));
    check({tag, "_seq"}, PW'(dataOut_seq), PW'(seq));
    check({tag, "_lost"}, PW'(packetLost), PW'(lost));
`ifdef STREAM_PARSER_GAP_COUNT_EN
    check({tag, "_gap"}, PW'(lostCount), PW'(gap));
`endif
    $display("pkt %s stream=%0h seq=%0h bytes=%0d lost=%0b gap=%0h",
             tag, dataOut_stream, dataOut_seq, dataOut_bytes, packetLost, gap);
    dataOut_ready = 1'b1;
    @(negedge clk);
    dataOut_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; dataIn = '0; dataIn_val = 1'b0; dataIN_last = 1'b0; dataOut_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_val", PW'(dataOut_val), PW'(0));
    check("rst_data", dataOut, PW'(0));
    check("rst_bytes", PW'(dataOut_bytes), PW'(0));
    check("rst_stream", PW'(dataOut_stream), PW'(0));
    check("rst_seq", PW'(dataOut_seq), PW'(0));
    check("rst_lost", PW'(packetLost), PW'(0));
    check("rst_lenErr", PW'(lenError), PW'(0));
    check("rst_ready", PW'(dataIn_ready), PW'(1));
    reset = 1'b0;
    @(negedge clk);

    // Basic packet: 5 payload bytes, valid two cycles after last word
    pl[0] = 32'hAABBCCDD; pl[1] = 32'h11223344;
    sendPkt(16'h000D, 16'h0003, 32'd1, 2);
    check("t1_valEarly", PW'(dataOut_val), PW'(0));
    @(negedge clk);
    check("t1_valOnTime", PW'(dataOut_val), PW'(1));
    check("t1_payload", dataOut, {40'hAABBCCDD11, 256'h0});
    @(negedge clk);
    check("t1_holdSeq", PW'(dataOut_seq), PW'(1));
    popPkt("t1", 16'h0003, 32'd1, 5, 1'b0, 32'd0);
    check("t1_empty", PW'(dataOut_val), PW'(0));

    // Sequence gap on stream 3, then a fresh stream with a single byte
    pl[0] = 32'h01020304;
    sendPkt(16'h000C, 16'h0003, 32'd4, 1);
    popPkt("t2a", 16'h0003, 32'd4, 4, 1'b1, 32'd2);
    pl[0] = 32'h99887766;
    sendPkt(16'h0009, 16'h0005, 32'd1, 1);
    popPkt("t2b", 16'h0005, 32'd1, 1, 1'b0, 32'd0);

    // Largest legal packet: 37 payload bytes, byte b holds value b
    for (int k = 0; k < 10; k++) pl[k] = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
    sendPkt(16'd45, 16'h0006, 32'd1, 10);
    popPkt("tmax", 16'h0006, 32'd1, 37, 1'b0, 32'd0);

    // Malformed packets: all dropped with a one-cycle lenError pulse
    sendWord(32'h01000003, 1'b0);
    check("lenErr_long", PW'(lenError), PW'(1));
    sendWord(32'h0000_0001, 1'b0);
    check("lenErr_pulse", PW'(lenError), PW'(0));
    sendWord(32'h0000_0002, 1'b0);
    sendWord(32'h0000_0003, 1'b1);
    sendWord(32'h00080003, 1'b0);
    check("lenErr_short", PW'(lenError), PW'(1));
    sendWord(32'hDEADBEEF, 1'b1);
    sendWord(32'h000C0003, 1'b0);
    sendWord(32'd7, 1'b1);
    check("lenErr_seqLast", PW'(lenError), PW'(1));
    sendWord(32'h000C0003, 1'b0);
    sendWord(32'd9, 1'b0);
    sendWord(32'h12345678, 1'b0);
    check("lenErr_noLast", PW'(lenError), PW'(1));
    sendWord(32'h87654321, 1'b1);
    sendWord(32'h00100003, 1'b0);
    sendWord(32'd9, 1'b0);
    sendWord(32'h0BADF00D, 1'b1);
    check("lenErr_early", PW'(lenError), PW'(1));
    repeat (3) @(negedge clk);
    check("drop_noOut", PW'(dataOut_val), PW'(0));
    // Stream 0x23 aliases index 3 (last good seq 4): seq 5 is in order
    pl[0] = 32'hCAFEF00D;
    sendPkt(16'h000C, 16'h0023, 32'd5, 1);
    popPkt("t3", 16'h0023, 32'd5, 4, 1'b0, 32'd0);

    // Back-pressure: queue of two fills, third packet stalls on its data word
    pl[0] = 32'h5A5A5A5A;
    sendPkt(16'h000C, 16'h0007, 32'd1, 1);
    sendPkt(16'h000C, 16'h0007, 32'd2, 1);
    sendWord(32'h000C0007, 1'b0);
    sendWord(32'd3, 1'b0);
    dataIn = pl[0]; dataIN_last = 1'b1; dataIn_val = 1'b1;
    check("t4_blocked", PW'(dataIn_ready), PW'(0));
    repeat (2) @(negedge clk);
    check("t4_stillBlocked", PW'(dataIn_ready), PW'(0));
    check("t4_headSeq", PW'(dataOut_seq), PW'(1));
    $display("pkt t4a stream=%0h seq=%0h bytes=%0d lost=%0b", dataOut_stream, dataOut_seq, dataOut_bytes, packetLost);
    dataOut_ready = 1'b1;
    @(negedge clk);
    dataOut_ready = 1'b0;
    check("t4_unblocked", PW'(dataIn_ready), PW'(1));
    @(negedge clk);
    dataIn_val = 1'b0; dataIN_last = 1'b0;
    popPkt("t4b", 16'h0007, 32'd2, 4, 1'b0, 32'd0);
    popPkt("t4c", 16'h0007, 32'd3, 4, 1'b0, 32'd0);

    // Reset in the middle of a payload
    sendWord(32'h00100009, 1'b0);
    sendWord(32'd1, 1'b0);
    sendWord(32'h11111111, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_val", PW'(dataOut_val), PW'(0));
    pl[0] = 32'h33333333;
    sendPkt(16'h000C, 16'h0009, 32'd1, 1);
    popPkt("t5", 16'h0009, 32'd1, 4, 1'b0, 32'd0);

    // Sequence wrap: 0xFFFFFFFF followed by 0 is in order
    pl[0] = 32'h44444444;
    sendPkt(16'h0009, 16'h000A, 32'hFFFFFFFF, 1);
    popPkt("t6a", 16'h000A, 32'hFFFFFFFF, 1, 1'b1, 32'hFFFFFFFE);
    sendPkt(16'h0009, 16'h000A, 32'd0, 1);
    popPkt("t6b", 16'h000A, 32'd0, 1, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
